// File: rtl/pc_register_if.sv
// Fetch-stage PC bus: next-PC/hit from the fetch control, PC, stall and
// performance counters back from the register.
interface pc_register_if #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 16
);
    logic [WIDTH-1:0]     nextInst;
    logic                 hit;
    logic [WIDTH-1:0]     currentInst;
    logic                 stall;
    logic [CNT_WIDTH-1:0] missCycles;
    logic [CNT_WIDTH-1:0] missEvents;
    logic [CNT_WIDTH-1:0] advances;

    modport master (
        output nextInst, hit,
        input  currentInst, stall, missCycles, missEvents, advances
    );

    modport slave (
        input  nextInst, hit,
        output currentInst, stall, missCycles, missEvents, advances
    );
endinterface

// File: rtl/pc_register.sv
// Program counter for the fetch stage: advances on an I-cache hit, freezes on a
// miss, and keeps saturating miss/advance performance counters.
module pc_register #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter int               CNT_WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    pc_register_if.slave bus
);
    localparam int CNT_MISS_CYCLES = 0;
    localparam int CNT_MISS_EVENTS = 1;
    localparam int CNT_ADVANCES    = 2;
    localparam int NUM_CNT         = 3;

    logic [WIDTH-1:0]     current_inst_q, current_inst_d;
    logic                 prev_hit_q, prev_hit_d;
    logic [NUM_CNT-1:0]   cnt_inc;
    logic [CNT_WIDTH-1:0] cnt_val [NUM_CNT];

    always_comb begin
        current_inst_d = bus.hit ? bus.nextInst : current_inst_q;
        prev_hit_d     = bus.hit;
        cnt_inc        = '0;
        cnt_inc[CNT_MISS_CYCLES] = !bus.hit;
        cnt_inc[CNT_MISS_EVENTS] = !bus.hit && prev_hit_q;
        cnt_inc[CNT_ADVANCES]    = bus.hit;
    end

    // prev_hit resets to 1 so a miss right after reset counts as a new event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            current_inst_q <= RESET_PC;
            prev_hit_q     <= 1'b1;
        end else begin
            current_inst_q <= current_inst_d;
            prev_hit_q     <= prev_hit_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CNT; gi++) begin : gen_cnt
            logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

            // Saturate at all-ones rather than wrapping.
            always_comb begin
                cnt_d = cnt_q;
                if (cnt_inc[gi] && (cnt_q != {CNT_WIDTH{1'b1}}))
                    cnt_d = cnt_q + CNT_WIDTH'(1);
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    cnt_q <= '0;
                else
                    cnt_q <= cnt_d;
            end

            assign cnt_val[gi] = cnt_q;
        end
    endgenerate

    assign bus.currentInst = current_inst_q;
    assign bus.stall       = !bus.hit;
    assign bus.missCycles  = cnt_val[CNT_MISS_CYCLES];
    assign bus.missEvents  = cnt_val[CNT_MISS_EVENTS];
    assign bus.advances    = cnt_val[CNT_ADVANCES];
endmodule

// File: tb/tb_pc_register.sv
// Directed bench for pc_register: a 16-bit counter instance for the main
// scenarios and a 4-bit counter instance for saturation.
module tb_pc_register;
    logic clk;
    logic rst_n;
    logic rst_n_s;
    int   checks;
    int   passes;

    pc_register_if #(.WIDTH(16), .CNT_WIDTH(16)) bus ();
    pc_register_if #(.WIDTH(16), .CNT_WIDTH(4))  bus_s ();

    pc_register #(.WIDTH(16), .RESET_PC(16'h0000), .CNT_WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    pc_register #(.WIDTH(16), .RESET_PC(16'h0100), .CNT_WIDTH(4)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n_s),
        .bus   (bus_s.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        $display("t=%0t pc=%h stall=%b missCycles=%0d missEvents=%0d advances=%0d",
                 $time, bus.currentInst, bus.stall, bus.missCycles, bus.missEvents, bus.advances);
    endtask

    task automatic test_reset();
        bus.hit = 1'b0;
        bus.nextInst = 16'h0000;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.currentInst !== 16'h0000) $display("FAIL reset_pc: got %h expected 0000", bus.currentInst); else passes++;
        checks++; if (bus.missCycles !== 16'd0) $display("FAIL reset_missCycles: got %0d expected 0", bus.missCycles); else passes++;
        checks++; if (bus.missEvents !== 16'd0) $display("FAIL reset_missEvents: got %0d expected 0", bus.missEvents); else passes++;
        checks++; if (bus.advances !== 16'd0) $display("FAIL reset_advances: got %0d expected 0", bus.advances); else passes++;
        checks++; if (bus.stall !== 1'b1) $display("FAIL reset_stall: got %b expected 1", bus.stall); else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) step();
        checks++; if (bus.currentInst !== 16'h0000) $display("FAIL miss10_pc: got %h expected 0000", bus.currentInst); else passes++;
        checks++; if (bus.missCycles !== 16'd10) $display("FAIL miss10_missCycles: got %0d expected 10", bus.missCycles); else passes++;
        checks++; if (bus.missEvents !== 16'd1) $display("FAIL miss10_missEvents: got %0d expected 1", bus.missEvents); else passes++;
        checks++; if (bus.advances !== 16'd0) $display("FAIL miss10_advances: got %0d expected 0", bus.advances); else passes++;
    endtask

    task automatic test_advance();
        bus.hit = 1'b1;
        bus.nextInst = 16'h0002;
        step();
        checks++; if (bus.currentInst !== 16'h0002) $display("FAIL adv_pc0: got %h expected 0002", bus.currentInst); else passes++;
        bus.nextInst = 16'h0004;
        step();
        checks++; if (bus.currentInst !== 16'h0004) $display("FAIL adv_pc1: got %h expected 0004", bus.currentInst); else passes++;
        bus.nextInst = 16'h0006;
        step();
        checks++; if (bus.currentInst !== 16'h0006) $display("FAIL adv_pc2: got %h expected 0006", bus.currentInst); else passes++;
        checks++; if (bus.advances !== 16'd3) $display("FAIL adv_advances: got %0d expected 3", bus.advances); else passes++;
        checks++; if (bus.missCycles !== 16'd10) $display("FAIL adv_missCycles: got %0d expected 10", bus.missCycles); else passes++;
        // Reloading the same address is still an advance.
        step();
        checks++; if (bus.advances !== 16'd4) $display("FAIL adv_same: got %0d expected 4", bus.advances); else passes++;
    endtask

    task automatic test_stall_hold();
        bus.nextInst = 16'h0010;
        step();
        checks++; if (bus.currentInst !== 16'h0010) $display("FAIL stall_setup_pc: got %h expected 0010", bus.currentInst); else passes++;
        bus.hit = 1'b0;
        bus.nextInst = 16'hBEEF;
        #1;
        checks++; if (bus.stall !== 1'b1) $display("FAIL stall_comb: got %b expected 1", bus.stall); else passes++;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus.currentInst !== 16'h0010) $display("FAIL stall_hold%0d: got %h expected 0010", i, bus.currentInst); else passes++;
        end
        checks++; if (bus.missCycles !== 16'd13) $display("FAIL stall_missCycles: got %0d expected 13", bus.missCycles); else passes++;
        checks++; if (bus.missEvents !== 16'd2) $display("FAIL stall_missEvents: got %0d expected 2", bus.missEvents); else passes++;
        bus.hit = 1'b1;
        #1;
        checks++; if (bus.stall !== 1'b0) $display("FAIL unstall_comb: got %b expected 0", bus.stall); else passes++;
        step();
        checks++; if (bus.currentInst !== 16'hBEEF) $display("FAIL stall_release_pc: got %h expected beef", bus.currentInst); else passes++;
        checks++; if (bus.advances !== 16'd6) $display("FAIL stall_advances: got %0d expected 6", bus.advances); else passes++;
    endtask

    task automatic test_miss_events();
        logic [5:0] pattern;
        pattern = 6'b101001;  // applied LSB first: 1,0,0,1,0,1
        bus.nextInst = 16'h1234;
        for (int i = 0; i < 6; i++) begin
            bus.hit = pattern[i];
            step();
        end
        checks++; if (bus.missEvents !== 16'd4) $display("FAIL mev_missEvents: got %0d expected 4", bus.missEvents); else passes++;
        checks++; if (bus.missCycles !== 16'd16) $display("FAIL mev_missCycles: got %0d expected 16", bus.missCycles); else passes++;
        checks++; if (bus.advances !== 16'd9) $display("FAIL mev_advances: got %0d expected 9", bus.advances); else passes++;
        checks++; if (bus.currentInst !== 16'h1234) $display("FAIL mev_pc: got %h expected 1234", bus.currentInst); else passes++;
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.currentInst !== 16'h0000) $display("FAIL areset_pc: got %h expected 0000", bus.currentInst); else passes++;
        checks++; if (bus.missCycles !== 16'd0) $display("FAIL areset_missCycles: got %0d expected 0", bus.missCycles); else passes++;
        checks++; if (bus.missEvents !== 16'd0) $display("FAIL areset_missEvents: got %0d expected 0", bus.missEvents); else passes++;
        checks++; if (bus.advances !== 16'd0) $display("FAIL areset_advances: got %0d expected 0", bus.advances); else passes++;
        bus.hit = 1'b1;
        bus.nextInst = 16'h5555;
        step();
        checks++; if (bus.currentInst !== 16'h0000) $display("FAIL areset_held_pc: got %h expected 0000", bus.currentInst); else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++; if (bus.currentInst !== 16'h5555) $display("FAIL post_reset_pc: got %h expected 5555", bus.currentInst); else passes++;
        checks++; if (bus.advances !== 16'd1) $display("FAIL post_reset_advances: got %0d expected 1", bus.advances); else passes++;
        bus.hit = 1'b0;
        step();
        checks++; if (bus.missEvents !== 16'd1) $display("FAIL post_reset_missEvents: got %0d expected 1", bus.missEvents); else passes++;
        checks++; if (bus.missCycles !== 16'd1) $display("FAIL post_reset_missCycles: got %0d expected 1", bus.missCycles); else passes++;
    endtask

    task automatic test_saturation();
        bus_s.hit = 1'b0;
        bus_s.nextInst = 16'hABCD;
        #1;
        checks++; if (bus_s.currentInst !== 16'h0100) $display("FAIL sat_reset_pc: got %h expected 0100", bus_s.currentInst); else passes++;
        @(negedge clk);
        rst_n_s = 1'b1;
        repeat (14) step();
        checks++; if (bus_s.missCycles !== 4'd14) $display("FAIL sat_miss14: got %0d expected 14", bus_s.missCycles); else passes++;
        step();
        checks++; if (bus_s.missCycles !== 4'hF) $display("FAIL sat_miss15: got %0d expected 15", bus_s.missCycles); else passes++;
        repeat (5) step();
        checks++; if (bus_s.missCycles !== 4'hF) $display("FAIL sat_miss20: got %0d expected 15", bus_s.missCycles); else passes++;
        checks++; if (bus_s.missEvents !== 4'd1) $display("FAIL sat_missEvents: got %0d expected 1", bus_s.missEvents); else passes++;
        checks++; if (bus_s.currentInst !== 16'h0100) $display("FAIL sat_pc_hold: got %h expected 0100", bus_s.currentInst); else passes++;
        bus_s.hit = 1'b1;
        repeat (20) step();
        checks++; if (bus_s.advances !== 4'hF) $display("FAIL sat_advances: got %0d expected 15", bus_s.advances); else passes++;
        checks++; if (bus_s.missCycles !== 4'hF) $display("FAIL sat_miss_after: got %0d expected 15", bus_s.missCycles); else passes++;
        checks++; if (bus_s.currentInst !== 16'hABCD) $display("FAIL sat_pc_adv: got %h expected abcd", bus_s.currentInst); else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        rst_n = 1'b1;
        rst_n_s = 1'b0;
        bus.hit = 1'b0;
        bus.nextInst = 16'h0000;
        bus_s.hit = 1'b0;
        bus_s.nextInst = 16'h0000;
        test_reset();
        test_advance();
        test_stall_hold();
        test_miss_events();
        test_async_reset();
        test_saturation();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/pc_register.md
# pc_register

Program-counter register for the 16-bit MIPS-style fetch stage. It holds the address of the instruction currently being fetched (`currentInst`) and advances to the address supplied by next-PC logic (`nextInst`) only when the instruction cache reports a hit. On a miss it freezes the PC, so fetch stalls until the cache refills. The block also exports stall status and saturating performance counters for the fetch stage.

## Interface
- `WIDTH`, default 16: address width of `nextInst` and `currentInst`.
- `RESET_PC`, default 16'h0000: value loaded into the PC on reset.
- `CNT_WIDTH`, default 16: width of each performance counter.

- `clk`  input  1  rising-edge clock. One clock domain; reset is asynchronous and active-low.
- `rst_n`  input  1  asynchronous active-low reset.
- `nextInst`  input  WIDTH  candidate next PC from the next-PC mux.
- `hit`  input  1  instruction-cache hit. 1 allows the PC to advance; 0 stalls it.
- `currentInst`  output  WIDTH  current PC, registered.
- `stall`  output  1  combinational `!hit`.
- `missCycles`  output  CNT_WIDTH  number of cycles sampled with `hit`=0. Saturating.
- `missEvents`  output  CNT_WIDTH  number of hit→miss transitions. Saturating.
- `advances`  output  CNT_WIDTH  number of PC updates. Saturating.

## Operation
- On each rising `clk` edge with `rst_n`=1:
  - If `hit`=1: `currentInst` ← `nextInst`, loaded verbatim with no alignment or masking. `advances` increments.
  - If `hit`=0: `currentInst` holds. `missCycles` increments.
- Loading the same value (`nextInst`==`currentInst`, `hit`=1) counts as an advance.
- Miss-event detection:
  - Internal flop `prevHit` holds `hit` from the previous edge. It resets to 1.
  - `missEvents` increments on an edge where `hit`=0 and `prevHit`=1.
  - A miss in the first cycle after reset therefore counts as one event.
- Counters saturate at all-ones. They never wrap.
- `stall` is purely combinational from `hit`. It carries no register and no reset dependency.
- X on `hit` is not supported. The bench must always drive it to 0 or 1.

## Timing
- Reset is asserted asynchronously: `currentInst`=RESET_PC, `missCycles`=`missEvents`=`advances`=0, `prevHit`=1. This takes effect immediately, without a clock edge.
- Reset release is synchronized by the system. The first update happens on the first rising edge with `rst_n`=1.
- Reset asserted mid-stall or mid-advance overrides everything. No partial update survives.
- Latency:
  - `nextInst`→`currentInst` takes 1 cycle when `hit`=1.
  - `hit`→`stall` has 0-cycle (combinational) latency.
  - Counter outputs reflect an edge one cycle after the qualifying sample.
- No handshake beyond `hit`. `nextInst` is sampled only on edges where `hit`=1.
- All counters update in the same edge. Every cycle increments exactly one of `advances` and `missCycles`, so their sum equals the cycles elapsed since reset, until either counter saturates.

## Test plan
- Reset state: assert `rst_n`=0 with `hit`=0 and `nextInst`=0 → `currentInst`=0x0000 and all counters 0 without any clock edge. Release reset, hold `hit`=0 for 10 cycles → `currentInst` stays 0x0000, `missCycles`=10, `missEvents`=1.
- Advance: `hit`=1, drive `nextInst` = 0x0002, 0x0004, 0x0006 on consecutive cycles → `currentInst` follows one cycle later each time, `advances`=3.
- Stall hold: PC=0x0010; `hit`=0 for 3 cycles while `nextInst`=0xBEEF → `currentInst` stays 0x0010, `stall`=1. Set `hit`=1 → `currentInst`=0xBEEF on the next edge.
- Miss events: `hit` pattern 1,0,0,1,0,1 → `missEvents` increases by 2 and `missCycles` by 3.
- Async reset mid-run: PC=0x1234 with counters nonzero; pulse `rst_n` low between edges → `currentInst`=0x0000 and counters 0 immediately.
- Saturation: run with `CNT_WIDTH`=4 and `hit`=0 for 20 cycles → `missCycles` sticks at 0xF.
